// File: rtl/thresholding_pkg.sv
// ---------------------------------------------------------------------------
// thresholding_pkg
//   Definitions shared by the thresholding AXI adapter and the PE regroup
//   stage that sits directly behind it.
//   - mode_e       : how a regroup stage re-folds the element stream
//                    (PASS, SPLIT or GATHER).
//   - pad_bits     : rounds a bit width up to whole bytes, which is how the
//                    AXI-Stream tdata widths are sized.
//   - regroup_mode : picks the mode from the input/output parallelism.
// ---------------------------------------------------------------------------
package thresholding_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    SPLIT  = 2'd1,
    GATHER = 2'd2
  } mode_e;

  function automatic int pad_bits(input int width);
    return ((width + 7) / 8) * 8;
  endfunction

  function automatic mode_e regroup_mode(input int pe_in, input int pe_out);
    if (pe_in == pe_out) return PASS;
    if (pe_in > pe_out) return SPLIT;
    return GATHER;
  endfunction

endpackage

// File: rtl/thresholding_pe_regroup.sv
// ---------------------------------------------------------------------------
// thresholding_pe_regroup
//   Re-folds a stream of PE_IN elements per beat into PE_OUT elements per
//   beat without changing element order or values. The mode is fixed at
//   elaboration:
//     PASS   (PE_IN == PE_OUT) : one registered pipeline stage
//     SPLIT  (PE_IN >  PE_OUT) : one input beat -> K output beats
//     GATHER (PE_IN <  PE_OUT) : K input beats  -> one output beat
//   where K = max(PE_IN,PE_OUT) / min(PE_IN,PE_OUT).
//
// Parameters
//   W       element width in bits
//   C       channel count (multiple of both PE_IN and PE_OUT)
//   PE_IN   elements per input beat
//   PE_OUT  elements per output beat
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   s_axis_tready  out  input ready
//   s_axis_tvalid  in   input valid
//   s_axis_tdata   in   element e at [e*W +: W], padding bits ignored
//   m_axis_tready  in   output ready
//   m_axis_tvalid  out  output valid
//   m_axis_tdata   out  element e at [e*W +: W], padding bits driven 0
//
// Handshake: a beat moves on a rising edge where valid && ready. The output
// side never drops valid or changes data while stalled (valid && !ready).
// s_axis_tready is a function of local state and m_axis_tready only, never
// of s_axis_tvalid, and is held low while rst is asserted.
// ---------------------------------------------------------------------------
module thresholding_pe_regroup
  import thresholding_pkg::*;
#(
  parameter int W      = 8,
  parameter int C      = 1,
  parameter int PE_IN  = 1,
  parameter int PE_OUT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tvalid,
  input  logic [pad_bits(PE_IN*W)-1:0]    s_axis_tdata,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [pad_bits(PE_OUT*W)-1:0]   m_axis_tdata
);

  localparam int    IBITS = pad_bits(PE_IN * W);
  localparam int    OBITS = pad_bits(PE_OUT * W);
  localparam int    IEW   = PE_IN * W;   // used input bits
  localparam int    OEW   = PE_OUT * W;  // used output bits
  localparam int    K     = (PE_IN > PE_OUT) ? PE_IN / PE_OUT : PE_OUT / PE_IN;
  localparam mode_e MODE  = regroup_mode(PE_IN, PE_OUT);

  // Input padding bits carry no data; fold them into a sink so the whole
  // bus is consumed.
  logic unused_pad;
  assign unused_pad = ^s_axis_tdata[IBITS-1:0];

  if ((C % PE_IN) != 0 || (C % PE_OUT) != 0 ||
      ((PE_IN > PE_OUT) ? (PE_IN % PE_OUT) : (PE_OUT % PE_IN)) != 0) begin : g_bad_params
    $error("thresholding_pe_regroup: C must be a multiple of PE_IN and PE_OUT, and one PE must divide the other");
  end

  if (MODE == PASS) begin : g_pass
    logic             vld_q;
    logic [OBITS-1:0] dat_q;

    assign s_axis_tready = !rst && (!vld_q || m_axis_tready);
    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = dat_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (s_axis_tready) begin
        vld_q <= s_axis_tvalid;
        // Zero-extension clears the output padding bits.
        if (s_axis_tvalid) dat_q <= OBITS'(s_axis_tdata[IEW-1:0]);
      end
    end

  end else if (MODE == SPLIT) begin : g_split
    localparam int             IW   = $clog2(K);
    localparam logic [IW-1:0]  LAST = IW'(K - 1);

    logic [IEW-1:0] buf_q;
    logic           full_q;
    logic [IW-1:0]  idx_q;
    logic           s_fire;
    logic           m_fire;

    // Accept a new beat when empty, or when the last slice leaves this
    // cycle, so back-to-back input beats produce no output bubble.
    assign s_axis_tready = !rst && (!full_q || (m_axis_tready && idx_q == LAST));
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = full_q && m_axis_tready;
    assign m_axis_tvalid = full_q;
    assign m_axis_tdata  = OBITS'(buf_q[idx_q*OEW +: OEW]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        buf_q  <= '0;
        full_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        if (m_fire) begin
          if (idx_q == LAST) begin
            idx_q  <= '0;
            full_q <= 1'b0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        // A same-cycle reload overrides the wrap above: buffer stays full.
        if (s_fire) begin
          buf_q  <= s_axis_tdata[IEW-1:0];
          full_q <= 1'b1;
          idx_q  <= '0;
        end
      end
    end

  end else begin : g_gather
    localparam int             IW   = $clog2(K);
    localparam int             SW   = (K - 1) * IEW;
    localparam logic [IW-1:0]  LAST = IW'(K - 1);

    logic [SW-1:0]    stg_q;
    logic [IW-1:0]    cnt_q;
    logic [OBITS-1:0] obuf_q;
    logic             ovld_q;
    logic             s_fire;

    // Only the group-completing beat needs the output register to be free;
    // earlier beats of a group go to staging even while the output stalls.
    assign s_axis_tready = !rst && ((cnt_q != LAST) || !ovld_q || m_axis_tready);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = ovld_q;
    assign m_axis_tdata  = obuf_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_q  <= '0;
        cnt_q  <= '0;
        obuf_q <= '0;
        ovld_q <= 1'b0;
      end else begin
        if (ovld_q && m_axis_tready) ovld_q <= 1'b0;
        if (s_fire) begin
          if (cnt_q == LAST) begin
            // Earliest beat sits in the low slot, newest on top.
            obuf_q <= OBITS'({s_axis_tdata[IEW-1:0], stg_q});
            ovld_q <= 1'b1;
            cnt_q  <= '0;
          end else begin
            stg_q[cnt_q*IEW +: IEW] <= s_axis_tdata[IEW-1:0];
            cnt_q                   <= cnt_q + IW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_thresholding_pe_regroup.sv
// ---------------------------------------------------------------------------
// tb_thresholding_pe_regroup
//   Three instances of the regroup stage share one clock and reset:
//     u_pass   W=4, PE_IN=2, PE_OUT=2   (8-bit in, 8-bit out)
//     u_split  W=8, PE_IN=4, PE_OUT=1   (32-bit in, 8-bit out, K=4)
//     u_gather W=4, PE_IN=1, PE_OUT=2   (8-bit padded in, 8-bit out, K=2)
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_thresholding_pe_regroup;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       p_sv, p_sr, p_mv, p_mr;
  logic [7:0] p_sd, p_md;
  logic       s_sv, s_sr, s_mv, s_mr;
  logic [31:0] s_sd;
  logic [7:0] s_md;
  logic       g_sv, g_sr, g_mv, g_mr;
  logic [7:0] g_sd, g_md;

  thresholding_pe_regroup #(.W(4), .C(2), .PE_IN(2), .PE_OUT(2)) u_pass (
    .clk(clk), .rst(rst),
    .s_axis_tready(p_sr), .s_axis_tvalid(p_sv), .s_axis_tdata(p_sd),
    .m_axis_tready(p_mr), .m_axis_tvalid(p_mv), .m_axis_tdata(p_md)
  );

  thresholding_pe_regroup #(.W(8), .C(8), .PE_IN(4), .PE_OUT(1)) u_split (
    .clk(clk), .rst(rst),
    .s_axis_tready(s_sr), .s_axis_tvalid(s_sv), .s_axis_tdata(s_sd),
    .m_axis_tready(s_mr), .m_axis_tvalid(s_mv), .m_axis_tdata(s_md)
  );

  thresholding_pe_regroup #(.W(4), .C(2), .PE_IN(1), .PE_OUT(2)) u_gather (
    .clk(clk), .rst(rst),
    .s_axis_tready(g_sr), .s_axis_tvalid(g_sv), .s_axis_tdata(g_sd),
    .m_axis_tready(g_mr), .m_axis_tvalid(g_mv), .m_axis_tdata(g_md)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver helpers (m: 0=pass 1=split 2=gather) ----------------
  task automatic drive(input int m, input logic sv, input logic [31:0] sd, input logic mr);
    case (m)
      0: begin p_sv = sv; p_sd = sd[7:0]; p_mr = mr; end
      1: begin s_sv = sv; s_sd = sd;      s_mr = mr; end
      default: begin g_sv = sv; g_sd = sd[7:0]; g_mr = mr; end
    endcase
  endtask

  function automatic logic get_sr(input int m);
    case (m)
      0: return p_sr;
      1: return s_sr;
      default: return g_sr;
    endcase
  endfunction

  function automatic logic get_mv(input int m);
    case (m)
      0: return p_mv;
      1: return s_mv;
      default: return g_mv;
    endcase
  endfunction

  function automatic logic [31:0] get_md(input int m);
    case (m)
      0: return {24'd0, p_md};
      1: return {24'd0, s_md};
      default: return {24'd0, g_md};
    endcase
  endfunction

  // Random-backpressure run with an element-level reference model: every
  // accepted input beat is broken into elements, and expected output beats
  // are rebuilt from that element queue PE_OUT at a time.
  task automatic run_random(input int m, input int n_in, input int pe_in,
                            input int pe_out, input int w);
    logic [31:0] exp_q[$];
    logic [31:0] elem_q[$];
    logic [31:0] mask;
    logic [31:0] sd, md, prev_md, b;
    logic        sv, mr, sr, mv, prev_stall, pend;
    int          sent, cyc;
    mask = (32'd1 << w) - 32'd1;
    sd = '0; sv = 1'b0; pend = 1'b0; prev_stall = 1'b0; prev_md = '0;
    sent = 0; cyc = 0;
    while ((sent < n_in || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, get_mv(m)}, 32'd1);
        check("hold_data", get_md(m), prev_md);
      end
      if (!pend) begin
        if (sent < n_in && $urandom_range(0, 99) < 80) begin
          sv = 1'b1;
          sd = $urandom;
        end else begin
          sv = 1'b0;
        end
      end
      mr = ($urandom_range(0, 99) >= 30);
      drive(m, sv, sd, mr);
      #1;
      sr = get_sr(m);
      mv = get_mv(m);
      md = get_md(m);
      if (mv && mr) begin
        if (exp_q.size() == 0) check("spurious_out", {31'd0, mv}, 32'd0);
        else check("data", md, exp_q.pop_front());
      end
      prev_stall = mv && !mr;
      prev_md    = md;
      pend       = sv && !sr;
      if (sv && sr) begin
        sent++;
        for (int e = 0; e < pe_in; e++) elem_q.push_back((sd >> (e * w)) & mask);
        while (elem_q.size() >= pe_out) begin
          b = '0;
          for (int e = 0; e < pe_out; e++) b = b | (elem_q.pop_front() << (e * w));
          exp_q.push_back(b);
        end
      end
    end
    check("rand_sent", sent, n_in);
    check("rand_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    drive(m, 1'b0, 32'd0, 1'b1);
  endtask

  logic [7:0] split_exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  // ---------------- directed + random sequence ----------------
  initial begin
    p_sv = 0; p_sd = '0; p_mr = 1;
    s_sv = 0; s_sd = '0; s_mr = 1;
    g_sv = 0; g_sd = '0; g_mr = 1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_p_sr", {31'd0, p_sr}, 0);
    check("rst_p_mv", {31'd0, p_mv}, 0);
    check("rst_p_md", {24'd0, p_md}, 0);
    check("rst_s_sr", {31'd0, s_sr}, 0);
    check("rst_s_mv", {31'd0, s_mv}, 0);
    check("rst_s_md", {24'd0, s_md}, 0);
    check("rst_g_sr", {31'd0, g_sr}, 0);
    check("rst_g_mv", {31'd0, g_mv}, 0);
    check("rst_g_md", {24'd0, g_md}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_p_sr", {31'd0, p_sr}, 1);
    check("post_rst_s_sr", {31'd0, s_sr}, 1);
    check("post_rst_g_sr", {31'd0, g_sr}, 1);

    // PASS: 0x21, 0x43 each appear one cycle after acceptance
    @(negedge clk); p_sv = 1; p_sd = 8'h21;
    @(negedge clk); #1;
    check("pass_v0", {31'd0, p_mv}, 1);
    check("pass_d0", {24'd0, p_md}, 32'h21);
    p_sd = 8'h43;
    @(negedge clk); #1;
    check("pass_v1", {31'd0, p_mv}, 1);
    check("pass_d1", {24'd0, p_md}, 32'h43);
    p_sv = 0;
    @(negedge clk); #1;
    check("pass_idle", {31'd0, p_mv}, 0);

    // SPLIT: two words -> eight consecutive bytes, ready only on the last slice
    @(negedge clk); s_sv = 1; s_sd = 32'h44332211; #1;
    check("split_rdy_empty", {31'd0, s_sr}, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) s_sd = 32'h88776655;
      if (i == 4) s_sv = 0;
      #1;
      check("split_v", {31'd0, s_mv}, 1);
      check("split_d", {24'd0, s_md}, {24'd0, split_exp[i]});
      check("split_rdy", {31'd0, s_sr}, ((i % 4) == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk); #1;
    check("split_idle", {31'd0, s_mv}, 0);

    // GATHER: nibbles 1,2,3,4 with padding nibble set -> 0x21, 0x43
    @(negedge clk); g_sv = 1; g_sd = 8'hF1;
    @(negedge clk); #1;
    check("gath_v_half", {31'd0, g_mv}, 0);
    g_sd = 8'hF2;
    @(negedge clk); #1;
    check("gath_v0", {31'd0, g_mv}, 1);
    check("gath_d0", {24'd0, g_md}, 32'h21);
    check("gath_rdy", {31'd0, g_sr}, 1);
    g_sd = 8'hF3;
    @(negedge clk); #1;
    check("gath_v_half2", {31'd0, g_mv}, 0);
    g_sd = 8'hF4;
    @(negedge clk); #1;
    check("gath_v1", {31'd0, g_mv}, 1);
    check("gath_d1", {24'd0, g_md}, 32'h43);
    g_sv = 0;
    @(negedge clk); #1;
    check("gath_idle", {31'd0, g_mv}, 0);

    // GATHER: reset mid-group while a completed beat is stalled
    @(negedge clk); g_mr = 0; g_sv = 1; g_sd = 8'h0A;
    @(negedge clk); g_sd = 8'h0B;
    @(negedge clk); g_sd = 8'h0C; #1;
    check("gr_v_full", {31'd0, g_mv}, 1);
    check("gr_d_full", {24'd0, g_md}, 32'hBA);
    check("gr_rdy_stage", {31'd0, g_sr}, 1);
    @(negedge clk); g_sv = 0; #1;
    check("gr_v_held", {31'd0, g_mv}, 1);
    check("gr_d_held", {24'd0, g_md}, 32'hBA);
    check("gr_rdy_block", {31'd0, g_sr}, 0);
    rst = 1'b1; #1;
    check("gr_rst_v", {31'd0, g_mv}, 0);
    check("gr_rst_d", {24'd0, g_md}, 0);
    check("gr_rst_rdy", {31'd0, g_sr}, 0);
    @(negedge clk); rst = 1'b0; g_mr = 1; g_sv = 1; g_sd = 8'h06; #1;
    check("gr_rel_rdy", {31'd0, g_sr}, 1);
    @(negedge clk); g_sd = 8'h07; #1;
    check("gr_after_one", {31'd0, g_mv}, 0);
    @(negedge clk); g_sv = 0; #1;
    check("gr_new_v", {31'd0, g_mv}, 1);
    check("gr_new_d", {24'd0, g_md}, 32'h76);
    @(negedge clk); #1;
    check("gr_new_idle", {31'd0, g_mv}, 0);

    // Random backpressure, all modes
    run_random(0, 1000, 2, 2, 4);
    run_random(1, 250, 4, 1, 8);
    run_random(2, 1000, 1, 2, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/thresholding_pe_regroup.md
# thresholding_pe_regroup

Stream re-folding stage placed directly downstream of the thresholding AXI adapter. It consumes thresholding output beats carrying PE_IN channel results and re-emits the same element sequence with PE_OUT elements per beat. The following folded layer can then run at a different parallelism than the thresholding kernel, with no change to element order or value.

## Interface
- W, none: element width in bits; equals the upstream O_BITS.
- C, 1: channel count; requires C % PE_IN == 0 and C % PE_OUT == 0.
- PE_IN, 1: elements per input beat.
- PE_OUT, 1: elements per output beat; exactly one of PE_IN, PE_OUT divides the other.
- Derived K: max(PE_IN,PE_OUT)/min(PE_IN,PE_OUT).
- Derived IBITS = ((PE_IN*W+7)/8)*8 and OBITS = ((PE_OUT*W+7)/8)*8: byte-padded AXI-Stream widths.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tready  out  1  input ready.
- s_axis_tvalid  in  1  input valid.
- s_axis_tdata  in  IBITS  element e at [e*W+:W]; padding bits ignored.
- m_axis_tready  in  1  output ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  OBITS  element e at [e*W+:W]; padding bits driven 0.

## Operation
- Element order is preserved exactly: element 0 of the earliest beat leaves first.
- Mode is selected at elaboration from the parameters:
  - PASS (PE_IN == PE_OUT): one registered pipeline stage.
  - SPLIT (PE_IN > PE_OUT): one input beat yields K output beats.
  - GATHER (PE_IN < PE_OUT): K input beats yield one output beat.
- Elaboration fails with $error if the divisibility rules are violated.
- PASS:
  - Single data/valid register.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
- SPLIT:
  - Holding register buf, full flag, counter idx in [0,K-1].
  - m_axis_tvalid = full; m_axis_tdata = buf slice idx (elements idx*PE_OUT .. idx*PE_OUT+PE_OUT-1).
  - On output transfer, idx increments; it wraps to 0 and clears full after slice K-1.
  - s_axis_tready = !full || (m_axis_tready && idx == K-1).
  - An accept on the same cycle as the last slice transfer reloads buf, keeps full set and sets idx to 0.
- GATHER:
  - Staging shift register stg of (K-1)*PE_IN elements, counter cnt in [0,K-1], output register obuf plus valid.
  - An input accept with cnt < K-1 writes slot cnt and increments cnt.
  - An input accept with cnt == K-1 loads obuf = {input, stg}, sets valid and resets cnt to 0.
  - s_axis_tready = (cnt != K-1) || !m_axis_tvalid || m_axis_tready.
- Group boundaries stay aligned with channel-fold boundaries because C/PE_OUT is an integer. No explicit frame counter is kept.
- The block neither creates nor drops elements. Values are copied bit-exactly; there is no arithmetic.

## Timing
- Reset value of every output:
  - m_axis_tvalid = 0 and m_axis_tdata = 0.
  - s_axis_tready = 0 while rst is high; 1 in the first cycle after rst is released.
  - idx, cnt and all valid/full flags are 0.
- Reset asserted mid-operation discards partial groups and held beats immediately, since the reset is asynchronous.
- Latency from input accept to the corresponding m_axis_tvalid:
  - PASS and SPLIT: 1 cycle.
  - GATHER: 1 cycle after the K-th input beat.
- Throughput with m_axis_tready held high:
  - PASS: 1 beat/cycle.
  - SPLIT: 1 output beat/cycle, no bubble between input beats.
  - GATHER: 1 input beat/cycle.
- Handshake rules:
  - m_axis_tdata and m_axis_tvalid hold stable while valid && !ready.
  - s_axis_tready never depends combinationally on s_axis_tvalid.
  - m_axis_tready feeds s_axis_tready combinationally, one gate level.

## Structure
- Package thresholding_pkg holds the pad_bits(width) function and the mode enumeration (PASS, SPLIT, GATHER). The thresholding adapter reuses both.
- No sub-module: the three modes are generate branches of one module of roughly 200 lines.

## Test plan
- PASS, W=4, PE=2: stream 0x21, 0x43 with m_axis_tready=1 -> identical beats, one cycle later each.
- SPLIT, W=8, PE_IN=4, PE_OUT=1, C=8: input 0x44332211, then 0x88776655 -> outputs 11,22,33,44,55,66,77,88 on 8 consecutive cycles; s_axis_tready high only when idx==3.
- GATHER, W=4, PE_IN=1, PE_OUT=2 (IBITS=8, OBITS=8): inputs 0x01, 0x02, 0x03, 0x04 -> outputs 0x21, 0x43; input padding bits set to 1 are ignored.
- Random backpressure: 30% m_axis_tready low, 1000 beats, all modes -> scoreboard order exact; output stable while stalled.
- Reset pulse asserted mid-group in GATHER with cnt=1 -> m_axis_tvalid drops immediately; the next two inputs form the first output beat.
